// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - bus bundle for the writeback arbiter
//
// Purpose: groups the port-A, port-B and register-file write signals of
// wb_arbiter so they travel as a single interface.
//
// Signals:
//   a_valid/a_rd/a_data   ALU result (master -> arbiter), no backpressure
//   a_stall               arbiter asks upstream to hold port A
//   b_valid/b_rd/b_data   long-latency result (master -> arbiter)
//   b_ready               arbiter FIFO can accept a port-B item
//   w_en/w_reg/w_data     registered register-file write port
//   fifo_count            port-B FIFO occupancy
//   proto_err             sticky: a_valid seen while a_stall was high
//
// Modports: master drives the producer inputs, slave is the arbiter side.

interface wb_arbiter_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
);
  logic                     a_valid;
  logic [4:0]               a_rd;
  logic [XLEN-1:0]          a_data;
  logic                     a_stall;
  logic                     b_valid;
  logic                     b_ready;
  logic [4:0]               b_rd;
  logic [XLEN-1:0]          b_data;
  logic                     w_en;
  logic [4:0]               w_reg;
  logic [XLEN-1:0]          w_data;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     proto_err;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  a_stall, b_ready, w_en, w_reg, w_data, fifo_count, proto_err
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output a_stall, b_ready, w_en, w_reg, w_data, fifo_count, proto_err
  );
endinterface

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-port writeback arbiter for the register file
//
// Purpose: port A (single-cycle ALU results) always wins; port B
// (long-latency results) is buffered in a DEPTH-entry FIFO and written
// whenever A is idle. A starvation counter raises a_stall so that buffered
// port-B items are guaranteed to drain under a sustained A stream.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   wb_arbiter_if.slave (port A, port B, write port, status)
//
// Parameters: DEPTH (FIFO entries, power of two >= 2), XLEN (data width),
// STARVE_MAX (FIFO-head losses to A before a_stall, >= 1). DEPTH and XLEN
// must match the parameters of the connected interface instance.
//
// Build option: WB_FIFO_BYPASS_EN - when defined, a port-B item arriving at
// an empty, idle arbiter goes straight to the write register (1-cycle
// latency) instead of through the FIFO.

module wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int XLEN       = 64,
  parameter int STARVE_MAX = 8
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  // FIFO storage is not reset; validity is tracked by count/pointers only.
  logic [4:0]      mem_rd_q   [DEPTH];
  logic [XLEN-1:0] mem_data_q [DEPTH];

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            a_stall_q, a_stall_d;
  logic            proto_err_q, proto_err_d;
  logic            w_en_q, w_en_d;
  logic [4:0]      w_reg_q, w_reg_d;
  logic [XLEN-1:0] w_data_q, w_data_d;

  logic fifo_empty;
  logic fifo_full;
  logic b_ready;
  logic a_win;
  logic b_hs;
  logic push;
  logic pop;
  logic bypass;

  // Handshake and selection decode. b_ready only looks at registered count
  // (and rst), so there is no input-to-ready combinational path.
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(DEPTH));
    b_ready    = !rst && !fifo_full;
    a_win      = bus.a_valid && (bus.a_rd != 5'd0);
    b_hs       = bus.b_valid && b_ready;
    pop        = !a_win && !fifo_empty;
`ifdef WB_FIFO_BYPASS_EN
    bypass     = fifo_empty && !a_win && b_hs && (bus.b_rd != 5'd0);
`else
    bypass     = 1'b0;
`endif
    // rd=0 items complete the handshake but are never stored.
    push       = b_hs && (bus.b_rd != 5'd0) && !bypass;
  end

  // FIFO pointer/count update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Write-port register: A first, then FIFO head, then bypass. When nothing
  // is selected w_reg/w_data keep their last values.
  always_comb begin
    w_en_d   = 1'b0;
    w_reg_d  = w_reg_q;
    w_data_d = w_data_q;
    if (a_win) begin
      w_en_d   = 1'b1;
      w_reg_d  = bus.a_rd;
      w_data_d = bus.a_data;
    end else if (pop) begin
      w_en_d   = 1'b1;
      w_reg_d  = mem_rd_q[rd_ptr_q];
      w_data_d = mem_data_q[rd_ptr_q];
    end else if (bypass) begin
      w_en_d   = 1'b1;
      w_reg_d  = bus.b_rd;
      w_data_d = bus.b_data;
    end
  end

  // Starvation tracking. The counter saturates at STARVE_MAX; a_stall is a
  // registered view of "counter saturated or FIFO full", so it rises one
  // cycle after either condition and falls one cycle after both clear.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (a_win && (starve_q != SW'(STARVE_MAX))) begin
      starve_d = starve_q + SW'(1);
    end
    a_stall_d   = (starve_q == SW'(STARVE_MAX)) || fifo_full;
    proto_err_d = proto_err_q || (bus.a_valid && a_stall_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      a_stall_q   <= 1'b0;
      proto_err_q <= 1'b0;
      w_en_q      <= 1'b0;
      w_reg_q     <= '0;
      w_data_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      a_stall_q   <= a_stall_d;
      proto_err_q <= proto_err_d;
      w_en_q      <= w_en_d;
      w_reg_q     <= w_reg_d;
      w_data_q    <= w_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd_q[wr_ptr_q]   <= bus.b_rd;
      mem_data_q[wr_ptr_q] <= bus.b_data;
    end
  end

  assign bus.a_stall    = a_stall_q;
  assign bus.b_ready    = b_ready;
  assign bus.w_en       = w_en_q;
  assign bus.w_reg      = w_reg_q;
  assign bus.w_data     = w_data_q;
  assign bus.fifo_count = count_q;
  assign bus.proto_err  = proto_err_q;

endmodule
